// File: rtl/ftch_imem_pkg.sv
// Fetch <-> instruction-memory request/response packet types.
//   ftch_imem_pkt_t : request from fetch, addr = byte address
//   imem_ftch_pkt_t : response to fetch, data = instruction word
package ftch_imem_pkg;

    typedef struct packed {
        logic [31:0] addr;
    } ftch_imem_pkt_t;

    typedef struct packed {
        logic [31:0] data;
    } imem_ftch_pkt_t;

endpackage

// File: rtl/imem_ctl.sv
// imem_ctl: instruction-memory responder for the fetch request interface.
// Holds a word-addressed instruction array and answers a stable fetch
// request RD_LAT cycles after it is first presented. A loader port writes
// the array one word per cycle and can run at any time.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   ftch_imem_vld    fetch request valid (addr stable while high)
//   ftch_imem_pkt    request packet, .addr = byte address
//   ftch_imem_rdy    response valid for the currently presented addr
//   imem_ftch_pkt    response packet, .data = instruction word
//   imem_err         with rdy: address misaligned or out of range
//   ld_vld/addr/data loader word write
//   ld_rdy           always 1; every loader write takes one cycle
module imem_ctl
    import ftch_imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 2,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ftch_imem_vld,
    input  ftch_imem_pkt_t       ftch_imem_pkt,
    output logic                 ftch_imem_rdy,
    output imem_ftch_pkt_t       imem_ftch_pkt,
    output logic                 imem_err,
    input  logic                 ld_vld,
    input  logic [IDX_W-1:0]     ld_addr,
    input  logic [31:0]          ld_data,
    output logic                 ld_rdy
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHit
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       mem [DEPTH_WORDS];

    logic [31:0]       addr;
    logic              new_addr;
    logic              ld_hit;
    logic              do_start;
    logic              do_reload;
    logic              do_capture;
    logic [31:0]       cap_addr;
    logic [IDX_W-1:0]  cap_idx;
    logic              cap_err;
    logic [31:0]       cap_word;

    assign addr     = ftch_imem_pkt.addr;
    assign new_addr = (addr != req_addr_q);
    // A loader write to the word being fetched must restart the access.
    assign ld_hit   = ld_vld && (ld_addr == req_addr_q[IDX_W+1:2]);

    // Capture source: the incoming addr when starting with RD_LAT = 1,
    // otherwise the latched request address.
    assign cap_addr = do_start ? addr : req_addr_q;
    assign cap_idx  = cap_addr[IDX_W+1:2];
    assign cap_err  = (cap_addr[1:0] != 2'b00) || ((cap_addr >> (IDX_W + 2)) != 32'd0);
    // Forward a same-cycle loader write so a capture never sees stale data.
    assign cap_word = (ld_vld && (ld_addr == cap_idx)) ? ld_data : mem[cap_idx];

    always_comb begin
        do_start   = 1'b0;
        do_reload  = 1'b0;
        do_capture = 1'b0;
        state_d    = state_q;
        req_addr_d = req_addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (ftch_imem_vld) begin
                    do_start = 1'b1;
                end
            end
            StWait: begin
                if (!ftch_imem_vld) begin
                    state_d = StIdle;
                end else if (new_addr) begin
                    do_start = 1'b1;
                end else if (ld_hit) begin
                    do_reload = 1'b1;
                end else if (cnt_q <= CNT_W'(1)) begin
                    do_capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StHit: begin
                if (!ftch_imem_vld) begin
                    state_d = StIdle;
                end else if (new_addr) begin
                    do_start = 1'b1;
                end else if (ld_hit) begin
                    do_reload = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_start) begin
            req_addr_d = addr;
            if (RD_LAT == 1) begin
                do_capture = 1'b1;
            end else begin
                cnt_d   = CNT_RELOAD;
                state_d = StWait;
            end
        end

        if (do_reload) begin
            cnt_d   = CNT_RELOAD;
            state_d = StWait;
        end

        if (do_capture) begin
            data_d  = cap_err ? 32'h0 : cap_word;
            err_d   = cap_err;
            state_d = StHit;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            req_addr_q <= 32'h0;
            data_q     <= 32'h0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_vld) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // rdy is combinational so a changed or dropped request never sees a stale hit.
    assign ftch_imem_rdy      = (state_q == StHit) && ftch_imem_vld && !new_addr;
    assign imem_ftch_pkt.data = data_q;
    assign imem_err           = ftch_imem_rdy && err_q;
    assign ld_rdy             = 1'b1;

endmodule

// File: tb/tb_imem_ctl.sv
// Directed self-checking bench for imem_ctl (DEPTH_WORDS = 1024, RD_LAT = 2).
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_imem_ctl;
    import ftch_imem_pkg::*;

    logic           clk;
    logic           resetn;
    logic           vld;
    ftch_imem_pkt_t req;
    logic           rdy;
    imem_ftch_pkt_t rsp;
    logic           err;
    logic           ld_vld;
    logic [9:0]     ld_addr;
    logic [31:0]    ld_data;
    logic           ld_rdy;

    int checks;
    int failures;

    imem_ctl #(
        .DEPTH_WORDS(1024),
        .RD_LAT     (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ftch_imem_vld(vld),
        .ftch_imem_pkt(req),
        .ftch_imem_rdy(rdy),
        .imem_ftch_pkt(rsp),
        .imem_err     (err),
        .ld_vld       (ld_vld),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_rdy       (ld_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current cycle's outputs, then advance to the next cycle.
    task automatic chk(input string tag, input logic e_rdy, input logic [31:0] e_data,
                       input logic e_err);
        @(negedge clk);
        checks++;
        assert (rdy === e_rdy) else begin
            failures++;
            $error("FAIL %s rdy: observed=%0b expected=%0b", tag, rdy, e_rdy);
        end
        checks++;
        assert (rsp.data === e_data) else begin
            failures++;
            $error("FAIL %s data: observed=%h expected=%h", tag, rsp.data, e_data);
        end
        checks++;
        assert (err === e_err) else begin
            failures++;
            $error("FAIL %s err: observed=%0b expected=%0b", tag, err, e_err);
        end
        tick();
    endtask

    initial begin
        logic [31:0] pre [4];
        pre[0] = 32'h11111111;
        pre[1] = 32'h22222222;
        pre[2] = 32'h33333333;
        pre[3] = 32'h44444444;

        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        vld      = 1'b0;
        req.addr = 32'h0;
        ld_vld   = 1'b0;
        ld_addr  = '0;
        ld_data  = 32'h0;
        tick();
        chk("reset0", 1'b0, 32'h0, 1'b0);
        checks++;
        assert (ld_rdy === 1'b1) else begin
            failures++;
            $error("FAIL ld_rdy: observed=%0b expected=1", ld_rdy);
        end
        resetn = 1'b1;
        tick();

        // Preload, then reset again: array must survive.
        for (int i = 0; i < 4; i++) begin
            ld_vld  = 1'b1;
            ld_addr = 10'(i);
            ld_data = pre[i];
            tick();
        end
        ld_vld = 1'b0;
        resetn = 1'b0;
        chk("reset1", 1'b0, 32'h0, 1'b0);
        resetn = 1'b1;

        // Basic latency and hold.
        vld = 1'b1; req.addr = 32'h0;
        chk("lat_c0", 1'b0, 32'h0, 1'b0);
        chk("lat_c1", 1'b0, 32'h0, 1'b0);
        chk("lat_c2", 1'b1, 32'h11111111, 1'b0);
        chk("hold_c3", 1'b1, 32'h11111111, 1'b0);
        chk("hold_c4", 1'b1, 32'h11111111, 1'b0);

        // Abort 0x4 after one cycle, redirect to 0xC.
        req.addr = 32'h4;
        chk("redir_4", 1'b0, 32'h11111111, 1'b0);
        req.addr = 32'hC;
        chk("redir_c0", 1'b0, 32'h11111111, 1'b0);
        chk("redir_c1", 1'b0, 32'h11111111, 1'b0);
        chk("redir_c2", 1'b1, 32'h44444444, 1'b0);

        // Stall in HIT, drop vld, advance.
        vld = 1'b0;
        chk("gap0", 1'b0, 32'h44444444, 1'b0);
        vld = 1'b1; req.addr = 32'h8;
        chk("stall_c0", 1'b0, 32'h44444444, 1'b0);
        chk("stall_c1", 1'b0, 32'h44444444, 1'b0);
        for (int i = 0; i < 5; i++) chk("stall_hold", 1'b1, 32'h33333333, 1'b0);
        vld = 1'b0;
        chk("stall_gap", 1'b0, 32'h33333333, 1'b0);
        vld = 1'b1; req.addr = 32'hC;
        chk("adv_c0", 1'b0, 32'h33333333, 1'b0);
        chk("adv_c1", 1'b0, 32'h33333333, 1'b0);
        chk("adv_c2", 1'b1, 32'h44444444, 1'b0);

        // Coherency: write to the in-flight index delays rdy.
        vld = 1'b0;
        chk("gap1", 1'b0, 32'h44444444, 1'b0);
        vld = 1'b1; req.addr = 32'h4;
        chk("coh_c0", 1'b0, 32'h44444444, 1'b0);
        ld_vld = 1'b1; ld_addr = 10'd1; ld_data = 32'hDEADBEEF;
        chk("coh_wr", 1'b0, 32'h44444444, 1'b0);
        ld_vld = 1'b0;
        chk("coh_c2", 1'b0, 32'h44444444, 1'b0);
        chk("coh_c3", 1'b1, 32'hDEADBEEF, 1'b0);

        // Write to another index does not delay.
        vld = 1'b0;
        chk("gap2", 1'b0, 32'hDEADBEEF, 1'b0);
        vld = 1'b1; req.addr = 32'h4;
        chk("oth_c0", 1'b0, 32'hDEADBEEF, 1'b0);
        ld_vld = 1'b1; ld_addr = 10'd2; ld_data = 32'h55555555;
        chk("oth_wr", 1'b0, 32'hDEADBEEF, 1'b0);
        ld_vld = 1'b0;
        chk("oth_c2", 1'b1, 32'hDEADBEEF, 1'b0);
        vld = 1'b0;
        chk("gap3", 1'b0, 32'hDEADBEEF, 1'b0);
        vld = 1'b1; req.addr = 32'h8;
        chk("rd2_c0", 1'b0, 32'hDEADBEEF, 1'b0);
        chk("rd2_c1", 1'b0, 32'hDEADBEEF, 1'b0);
        chk("rd2_c2", 1'b1, 32'h55555555, 1'b0);

        // Errors: misaligned, then out of range, then a good address.
        vld = 1'b0;
        chk("gap4", 1'b0, 32'h55555555, 1'b0);
        vld = 1'b1; req.addr = 32'h6;
        chk("mis_c0", 1'b0, 32'h55555555, 1'b0);
        chk("mis_c1", 1'b0, 32'h55555555, 1'b0);
        chk("mis_c2", 1'b1, 32'h0, 1'b1);
        req.addr = 32'h1000;
        chk("oor_c0", 1'b0, 32'h0, 1'b0);
        chk("oor_c1", 1'b0, 32'h0, 1'b0);
        chk("oor_c2", 1'b1, 32'h0, 1'b1);
        req.addr = 32'h0;
        chk("ok_c0", 1'b0, 32'h0, 1'b0);
        chk("ok_c1", 1'b0, 32'h0, 1'b0);
        chk("ok_c2", 1'b1, 32'h11111111, 1'b0);

        // Reset during WAIT aborts; array retained.
        vld = 1'b0;
        chk("gap5", 1'b0, 32'h11111111, 1'b0);
        vld = 1'b1; req.addr = 32'h4;
        chk("rw_c0", 1'b0, 32'h11111111, 1'b0);
        resetn = 1'b0;
        chk("rw_rst", 1'b0, 32'h0, 1'b0);
        resetn = 1'b1; req.addr = 32'h0;
        chk("rr_c0", 1'b0, 32'h0, 1'b0);
        chk("rr_c1", 1'b0, 32'h0, 1'b0);
        chk("rr_c2", 1'b1, 32'h11111111, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
